// File: rtl/pipeline_input_buffer.sv
// Dual-channel first-word-fall-through input queue feeding pipeline_wrapped.
// Each channel is an independent FIFO; the top only shares the saturating flush-drop counter.

module pipeline_input_buffer_chan #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic              offer_o,
    output logic [CNT_W-1:0]  count_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop, nonempty;

    assign nonempty = (cnt_q != '0);
    // Ready ignores the same-cycle pop: a full queue refuses even while draining.
    assign ready_o  = ~rst_i & (cnt_q < CNT_W'(DEPTH)) & ~flush_i;
    assign push     = valid_i & ready_o;
    assign offer_o  = nonempty & ~stall_i & ~flush_i;
    assign pop      = offer_o;
    assign head_o   = nonempty ? mem_q[rd_q] : '0;
    assign count_o  = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the count is zero.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end
endmodule

module pipeline_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] src1_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    input  logic [DATA_W-1:0] src2_data,
    input  logic              src2_valid,
    output logic              src2_ready,
    input  logic              stall_1,
    input  logic              stall_2,
    input  logic              flush_1,
    input  logic              flush_2,
    output logic [DATA_W-1:0] pipeline1_inputs,
    output logic [DATA_W-1:0] pipeline2_inputs,
    output logic [1:0]        in_valid,
    output logic [CNT_W-1:0]  count1,
    output logic [CNT_W-1:0]  count2,
    output logic [7:0]        flush_drops
);
    localparam int SUM_W = CNT_W + 9;

    logic [7:0]       drops_q, drops_d;
    logic [SUM_W-1:0] drop_sum;

    pipeline_input_buffer_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch1 (
        .clk_i(clk), .rst_i(reset),
        .data_i(src1_data), .valid_i(src1_valid), .ready_o(src1_ready),
        .stall_i(stall_1), .flush_i(flush_1),
        .head_o(pipeline1_inputs), .offer_o(in_valid[0]), .count_o(count1)
    );

    pipeline_input_buffer_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch2 (
        .clk_i(clk), .rst_i(reset),
        .data_i(src2_data), .valid_i(src2_valid), .ready_o(src2_ready),
        .stall_i(stall_2), .flush_i(flush_2),
        .head_o(pipeline2_inputs), .offer_o(in_valid[1]), .count_o(count2)
    );

    // Wide enough that two full channels plus 255 cannot wrap before saturation.
    always_comb begin
        drop_sum = SUM_W'(drops_q)
                 + (flush_1 ? SUM_W'(count1) : '0)
                 + (flush_2 ? SUM_W'(count2) : '0);
        drops_d  = (drop_sum > SUM_W'(255)) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drops_q <= '0;
        else       drops_q <= drops_d;
    end

    assign flush_drops = drops_q;
endmodule

// File: tb/tb_pipeline_input_buffer.sv
// Directed bench for pipeline_input_buffer (DATA_W=32, DEPTH=4).
// Inputs change 1ns after a rising edge; outputs are checked 1ns after that.

module tb_pipeline_input_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] src1_data, src2_data;
    logic              src1_valid, src2_valid;
    logic              src1_ready, src2_ready;
    logic              stall_1, stall_2, flush_1, flush_2;
    logic [DATA_W-1:0] pipeline1_inputs, pipeline2_inputs;
    logic [1:0]        in_valid;
    logic [CNT_W-1:0]  count1, count2;
    logic [7:0]        flush_drops;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .src2_data(src2_data), .src2_valid(src2_valid), .src2_ready(src2_ready),
        .stall_1(stall_1), .stall_2(stall_2), .flush_1(flush_1), .flush_2(flush_2),
        .pipeline1_inputs(pipeline1_inputs), .pipeline2_inputs(pipeline2_inputs),
        .in_valid(in_valid), .count1(count1), .count2(count2),
        .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set beforehand are sampled there, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_w [5];

        reset = 1'b1;
        src1_data = '0; src2_data = '0; src1_valid = 1'b0; src2_valid = 1'b0;
        stall_1 = 1'b0; stall_2 = 1'b0; flush_1 = 1'b0; flush_2 = 1'b0;
        tick(); tick();
        chk("rst_in_valid", 32'(in_valid), 32'h0);
        chk("rst_count1", 32'(count1), 32'h0);
        chk("rst_count2", 32'(count2), 32'h0);
        chk("rst_drops", 32'(flush_drops), 32'h0);
        chk("rst_data1", pipeline1_inputs, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready1", 32'(src1_ready), 32'h1);
        chk("post_rst_ready2", 32'(src2_ready), 32'h1);

        // 1: two words flow through unstalled, one cycle after each push
        src1_valid = 1'b1; src1_data = 32'h11;
        tick();
        chk("t1_v0", 32'(in_valid[0]), 32'h1);
        chk("t1_head0", pipeline1_inputs, 32'h11);
        chk("t1_cnt0", 32'(count1), 32'h1);
        src1_data = 32'h22;
        tick();
        chk("t1_v1", 32'(in_valid[0]), 32'h1);
        chk("t1_head1", pipeline1_inputs, 32'h22);
        chk("t1_ready", 32'(src1_ready), 32'h1);
        src1_valid = 1'b0;
        tick();
        chk("t1_empty_v", 32'(in_valid[0]), 32'h0);
        chk("t1_empty_cnt", 32'(count1), 32'h0);
        chk("t1_empty_data", pipeline1_inputs, 32'h0);

        // 2: fill while stalled, fifth refused, then drain in order
        stall_1 = 1'b1;
        for (int i = 0; i < 5; i++) exp_w[i] = 32'hA1 + 32'(i);
        for (int i = 0; i < 5; i++) begin
            src1_valid = 1'b1; src1_data = exp_w[i];
            tick();
            chk("t2_cnt", 32'(count1), (i < 4) ? 32'(i + 1) : 32'd4);
            chk("t2_stall_v", 32'(in_valid[0]), 32'h0);
        end
        chk("t2_full_ready", 32'(src1_ready), 32'h0);
        src1_valid = 1'b0; stall_1 = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_v", 32'(in_valid[0]), 32'h1);
            chk("t2_drain_data", pipeline1_inputs, exp_w[i]);
            tick();
        end
        chk("t2_drained", 32'(count1), 32'h0);

        // 3: flush a 3-deep ch2 while a push is offered
        stall_2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src2_valid = 1'b1; src2_data = 32'hB1 + 32'(i);
            tick();
        end
        chk("t3_cnt_pre", 32'(count2), 32'h3);
        src2_data = 32'hBF; flush_2 = 1'b1; stall_2 = 1'b0;
        #1;
        chk("t3_flush_ready", 32'(src2_ready), 32'h0);
        chk("t3_flush_v", 32'(in_valid[1]), 32'h0);
        tick();
        flush_2 = 1'b0; src2_valid = 1'b0;
        #1;
        chk("t3_cnt", 32'(count2), 32'h0);
        chk("t3_v", 32'(in_valid[1]), 32'h0);
        chk("t3_drops", 32'(flush_drops), 32'h3);
        tick();
        chk("t3_discarded", 32'(count2), 32'h0);

        // 4: steady push+pop across pointer wrap
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            src1_valid = 1'b1; src1_data = 32'hC0 + 32'(i);
            tick();
            chk("t4_cnt", 32'(count1), 32'h1);
            chk("t4_data", pipeline1_inputs, 32'hC0 + 32'(i));
        end
        src1_valid = 1'b0;
        tick();
        chk("t4_end_cnt", 32'(count1), 32'h0);

        // 5: ch1 stalled while ch2 flows
        stall_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src1_valid = 1'b1; src1_data = 32'hD1 + 32'(i);
            src2_valid = 1'b1; src2_data = 32'hE1 + 32'(i);
            tick();
            chk("t5_cnt1", 32'(count1), 32'(i + 1));
            chk("t5_cnt2", 32'(count2), 32'h1);
            chk("t5_head1", pipeline1_inputs, 32'hD1);
            chk("t5_head2", pipeline2_inputs, 32'hE1 + 32'(i));
            chk("t5_v", 32'(in_valid), 32'h2);
        end
        src1_valid = 1'b0; src2_valid = 1'b0;
        tick();
        chk("t5_ch2_drained", 32'(count2), 32'h0);
        chk("t5_ch1_held", pipeline1_inputs, 32'hD1);
        chk("t5_ch1_cnt", 32'(count1), 32'h3);
        stall_1 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_ch1_drain", pipeline1_inputs, 32'hD1 + 32'(i));
            tick();
        end
        chk("t5_ch1_empty", 32'(count1), 32'h0);

        // 6: asynchronous reset with both queues holding data
        stall_1 = 1'b1; stall_2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            src1_valid = 1'b1; src1_data = 32'hF1 + 32'(i);
            src2_valid = 1'b1; src2_data = 32'hF5 + 32'(i);
            tick();
        end
        src1_valid = 1'b0; src2_valid = 1'b0; stall_1 = 1'b0; stall_2 = 1'b0;
        #1;
        chk("t6_pre_v", 32'(in_valid), 32'h3);
        reset = 1'b1;
        #1;
        chk("t6_v", 32'(in_valid), 32'h0);
        chk("t6_cnt1", 32'(count1), 32'h0);
        chk("t6_cnt2", 32'(count2), 32'h0);
        chk("t6_data1", pipeline1_inputs, 32'h0);
        chk("t6_data2", pipeline2_inputs, 32'h0);
        chk("t6_drops", 32'(flush_drops), 32'h0);
        tick();
        reset = 1'b0;
        src1_valid = 1'b1; src1_data = 32'h77;
        tick();
        src1_valid = 1'b0;
        chk("t6_resume_data", pipeline1_inputs, 32'h77);
        chk("t6_resume_cnt", 32'(count1), 32'h1);
        tick();

        // Simultaneous flush of both channels sums their occupancy
        stall_1 = 1'b1; stall_2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            src1_valid = 1'b1; src2_valid = 1'b1; src2_data = 32'h55;
            tick();
        end
        src1_valid = 1'b0; src2_valid = 1'b0;
        flush_1 = 1'b1; flush_2 = 1'b1;
        tick();
        flush_1 = 1'b0; flush_2 = 1'b0;
        chk("both_flush_drops", 32'(flush_drops), 32'h4);

        // Saturation: 4 + 64*4 discarded entries caps at 255
        for (int r = 0; r < 64; r++) begin
            src1_valid = 1'b1;
            for (int i = 0; i < DEPTH; i++) tick();
            src1_valid = 1'b0; flush_1 = 1'b1;
            tick();
            flush_1 = 1'b0;
        end
        chk("sat_drops", 32'(flush_drops), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
